dispatch_ctrl: RTL and testbench
================================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 The block SHALL have parameter IQ_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-004 The block SHALL have port rdy, input, 1: global enable; when low, all state holds.
REQ-005 The block SHALL have ports in_fetcher_valid (input, 1), in_fetcher_instr (input, 32), in_fetcher_pc (input, 32) and in_fetcher_jump_ce (input, 1), carrying the fetched instruction, its PC and its predicted-taken flag.
REQ-006 The block SHALL have port out_fetcher_ready, output, 1: queue can accept an instruction this cycle.
REQ-007 The block SHALL have ports in_rob_full, in_rs_full and in_lsb_full, input, 1 each: no free entry in the ROB, RS or LSB.
REQ-008 The block SHALL have port in_rob_flush, input, 1: mispredict or flush request.
REQ-009 The block SHALL have ports out_decode_valid (output, 1), out_decode_instr (output, 32), out_decode_pc (output, 32) and out_decode_jump_ce (output, 1), all registered, forming the instruction presented to decode.
REQ-010 The block SHALL have port out_stall_reason, output, 2: 0 none, 1 ROB full, 2 RS full, 3 LSB full.

Function
REQ-011 Class SHALL be taken from the head entry's opcode [6:0]:
- 0000011 and 0100011 -> LSB.
- 0110111, 0010111, 1101111, 1100111, 1100011, 0010011, 0110011 -> RS.
- All others -> INVALID.
REQ-012 Push SHALL occur when in_fetcher_valid && out_fetcher_ready && rdy; the entry is written at the tail, and the tail pointer increments modulo IQ_DEPTH.
REQ-013 out_fetcher_ready SHALL be combinational: (count < IQ_DEPTH) && state != FLUSH; there is no bypass when full, even if a pop occurs the same cycle.
REQ-014 Dispatch SHALL fire when all of the following hold: rdy; state != FLUSH; count > 0; head class RS or LSB; !in_rob_full; and the matching !in_rs_full or !in_lsb_full.
REQ-015 On dispatch the head entry SHALL be popped, and next cycle out_decode_valid SHALL be 1 with the head's instr, pc and jump_ce.
REQ-016 out_decode_valid SHALL be 1 for exactly one cycle per dispatched instruction and 0 otherwise; data outputs hold their last value while valid is 0.
REQ-017 An INVALID head SHALL be popped with no dispatch (out_decode_valid stays 0), consuming one cycle regardless of resource state.
REQ-018 At most one pop per cycle SHALL occur.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged.
REQ-020 Minimum latency SHALL be: instruction accepted at edge N -> out_decode_valid high after edge N+1.
REQ-021 The FSM SHALL have states RUN, STALL and FLUSH.
- RUN -> STALL: count>0 and head is RS/LSB but dispatch is blocked.
- STALL -> RUN: dispatch fires or the queue becomes empty.
- Any state -> FLUSH: in_rob_flush=1.
- FLUSH -> RUN: after exactly one cycle, unless in_rob_flush is still 1, in which case it remains in FLUSH.
REQ-022 out_stall_reason SHALL be registered and updated each cycle in which rdy=1; the blocking cause is evaluated with ROB first, then RS/LSB.
- If the cycle's blocking cause is ROB full, out_stall_reason SHALL be 1.
- If the cycle's blocking cause is RS full or LSB full, out_stall_reason SHALL be 2 or 3 respectively.
- It SHALL be 0 when dispatch fires or nothing is pending.
REQ-023 When in_rob_flush=1 with rdy=1, the next edge SHALL:
- clear head, tail and count;
- force out_decode_valid=0 and out_stall_reason=0;
- drop any same-cycle push and any same-cycle dispatch.
REQ-024 Flush SHALL take priority over push, pop and every FSM transition.
REQ-025 Pointer wrap-around SHALL be seamless; FIFO order is preserved across the wrap.
REQ-026 rdy=0 SHALL freeze queue contents, pointers, count, FSM state and all registered outputs; no push or pop occurs.

Reset
REQ-027 While rst=1, asynchronously:
- head, tail and count SHALL be 0 and state SHALL be RUN;
- out_decode_valid, out_decode_jump_ce and out_stall_reason SHALL be 0;
- out_decode_instr and out_decode_pc SHALL be 32'h0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; after deassertion out_fetcher_ready=1 as soon as rdy=1.

Verification
REQ-029 Stream: push ADDI (0x00100093, pc 0x0) at edge 0, resources free -> out_decode_valid=1 after edge 1 with instr 0x00100093 and pc 0x0, then 0 the following cycle.
REQ-030 Full stall: hold in_rob_full=1 and push 4 instructions -> out_fetcher_ready=0, state STALL, out_stall_reason=1. Release in_rob_full -> 4 consecutive valid cycles in push order.
REQ-031 Class blocking: head LW (0x00002103) with in_lsb_full=1 and in_rs_full=0 -> no dispatch, out_stall_reason=3, and the following ADD stays queued behind it.
REQ-032 Flush: queue holds 3 entries and in_fetcher_valid=1 when in_rob_flush pulses -> count=0, out_decode_valid=0, out_fetcher_ready=0 for one cycle, then 1.
REQ-033 Invalid opcode 0x0000000F at head -> popped in one cycle with no decode valid, and the next RS instruction dispatches the following cycle.
REQ-034 Wrap and rdy: push/pop 10 instructions with rdy toggled low for 3 cycles mid-stream -> all 10 emerge in order with no duplicates, and state is unchanged during rdy=0.

Source files
------------

// File: rtl/dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_ctrl_if
// Brief   : Fetcher, resource-status, flush and decode signals of dispatch_ctrl.
// Revision: 1.0
// ============================================================================
interface dispatch_ctrl_if;
  logic        in_fetcher_valid;
  logic [31:0] in_fetcher_instr;
  logic [31:0] in_fetcher_pc;
  logic        in_fetcher_jump_ce;
  logic        out_fetcher_ready;
  logic        in_rob_full;
  logic        in_rs_full;
  logic        in_lsb_full;
  logic        in_rob_flush;
  logic        out_decode_valid;
  logic [31:0] out_decode_instr;
  logic [31:0] out_decode_pc;
  logic        out_decode_jump_ce;
  logic [1:0]  out_stall_reason;

  modport master (
    output in_fetcher_valid, in_fetcher_instr, in_fetcher_pc, in_fetcher_jump_ce,
    output in_rob_full, in_rs_full, in_lsb_full, in_rob_flush,
    input  out_fetcher_ready, out_decode_valid, out_decode_instr, out_decode_pc,
    input  out_decode_jump_ce, out_stall_reason
  );

  modport slave (
    input  in_fetcher_valid, in_fetcher_instr, in_fetcher_pc, in_fetcher_jump_ce,
    input  in_rob_full, in_rs_full, in_lsb_full, in_rob_flush,
    output out_fetcher_ready, out_decode_valid, out_decode_instr, out_decode_pc,
    output out_decode_jump_ce, out_stall_reason
  );
endinterface
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_ctrl
// Brief   : Instruction queue that classifies the head and dispatches to RS/LSB.
// Revision: 1.0
// ============================================================================
module dispatch_ctrl #(
  parameter int IQ_DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       rdy,
  dispatch_ctrl_if.slave  bus
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(IQ_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          dec_valid_q, dec_valid_d;
  logic [31:0]   dec_instr_q, dec_instr_d;
  logic [31:0]   dec_pc_q, dec_pc_d;
  logic          dec_jce_q, dec_jce_d;
  logic [1:0]    stall_q, stall_d;

  logic [31:0]   mem_instr [IQ_DEPTH];
  logic [31:0]   mem_pc    [IQ_DEPTH];
  logic          mem_jce   [IQ_DEPTH];

  logic [31:0]   head_instr;
  logic [31:0]   head_pc;
  logic          head_jce;
  logic          is_rs, is_lsb, is_inv;
  logic          not_empty, flush, ready;
  logic          pending, res_blocked, dispatch, drop, push, pop;

  assign head_instr = mem_instr[head_q];
  assign head_pc    = mem_pc[head_q];
  assign head_jce   = mem_jce[head_q];

  always_comb begin
    is_rs  = 1'b0;
    is_lsb = 1'b0;
    case (head_instr[6:0])
      7'b0000011, 7'b0100011: is_lsb = 1'b1;
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b1100011, 7'b0010011, 7'b0110011: is_rs = 1'b1;
      default: ;
    endcase
  end
  assign is_inv = !is_rs && !is_lsb;

  assign not_empty   = (count_q != '0);
  assign flush       = bus.in_rob_flush;
  // No full bypass: a same-cycle pop does not make room for a push.
  assign ready       = (count_q != CNT_FULL) && (state_q != FLUSH);
  assign pending     = not_empty && !is_inv && (state_q != FLUSH);
  assign res_blocked = bus.in_rob_full || (is_rs && bus.in_rs_full) ||
                       (is_lsb && bus.in_lsb_full);
  assign dispatch    = rdy && !flush && pending && !res_blocked;
  assign drop        = rdy && !flush && not_empty && is_inv && (state_q != FLUSH);
  assign pop         = dispatch || drop;
  assign push        = rdy && !flush && bus.in_fetcher_valid && ready;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    dec_valid_d = 1'b0;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    dec_jce_d   = dec_jce_q;
    stall_d     = 2'd0;

    if (push) tail_d = tail_q + PTR_ONE;
    if (pop)  head_d = head_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (dispatch) begin
      dec_valid_d = 1'b1;
      dec_instr_d = head_instr;
      dec_pc_d    = head_pc;
      dec_jce_d   = head_jce;
    end

    // ROB is reported ahead of the class-specific resource.
    if (pending) begin
      if (bus.in_rob_full)                stall_d = 2'd1;
      else if (is_rs && bus.in_rs_full)   stall_d = 2'd2;
      else if (is_lsb && bus.in_lsb_full) stall_d = 2'd3;
    end

    case (state_q)
      RUN:     if (pending && !dispatch) state_d = STALL;
      STALL:   if (dispatch || !not_empty) state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      state_d     = FLUSH;
      dec_valid_d = 1'b0;
      stall_d     = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= 32'h0;
      dec_pc_q    <= 32'h0;
      dec_jce_q   <= 1'b0;
      stall_q     <= 2'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      dec_jce_q   <= dec_jce_d;
      stall_q     <= stall_d;
    end
  end

  // Storage needs no reset: entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail_q] <= bus.in_fetcher_instr;
      mem_pc[tail_q]    <= bus.in_fetcher_pc;
      mem_jce[tail_q]   <= bus.in_fetcher_jump_ce;
    end
  end

  assign bus.out_fetcher_ready  = ready;
  assign bus.out_decode_valid   = dec_valid_q;
  assign bus.out_decode_instr   = dec_instr_q;
  assign bus.out_decode_pc      = dec_pc_q;
  assign bus.out_decode_jump_ce = dec_jce_q;
  assign bus.out_stall_reason   = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dispatch_ctrl
// Brief   : Directed self-checking bench for dispatch_ctrl.
// Revision: 1.0
// ============================================================================
module tb_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  dispatch_ctrl_if bus();

  dispatch_ctrl #(.IQ_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic j);
    bus.in_fetcher_valid   = v;
    bus.in_fetcher_instr   = ins;
    bus.in_fetcher_pc      = pc;
    bus.in_fetcher_jump_ce = j;
  endtask

  initial begin
    logic [31:0] st_frz, cnt_frz, exp_i;
    int pushed, got;
    logic will_push;

    rst = 1'b1;
    rdy = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    bus.in_rob_full  = 1'b0;
    bus.in_rs_full   = 1'b0;
    bus.in_lsb_full  = 1'b0;
    bus.in_rob_flush = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_valid", 32'(bus.out_decode_valid), 32'd0);
    chk("rst_instr", bus.out_decode_instr, 32'h0);
    chk("rst_pc", bus.out_decode_pc, 32'h0);
    chk("rst_jce", 32'(bus.out_decode_jump_ce), 32'd0);
    chk("rst_stall", 32'(bus.out_stall_reason), 32'd0);
    chk("rst_count", 32'(dut.count_q), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.out_fetcher_ready), 32'd1);

    // single ADDI stream
    drive(1'b1, 32'h00100093, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("s1_valid0", 32'(bus.out_decode_valid), 32'd0);
    tick();
    chk("s1_valid1", 32'(bus.out_decode_valid), 32'd1);
    chk("s1_instr", bus.out_decode_instr, 32'h00100093);
    chk("s1_pc", bus.out_decode_pc, 32'h0);
    tick();
    chk("s1_valid2", 32'(bus.out_decode_valid), 32'd0);
    chk("s1_hold", bus.out_decode_instr, 32'h00100093);

    // ROB full: fill queue, then drain in order
    bus.in_rob_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h00000013 | (32'(i) << 20), 32'h10 + 32'(i) * 4, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("rob_ready", 32'(bus.out_fetcher_ready), 32'd0);
    chk("rob_state", 32'(dut.state_q), 32'd1);
    chk("rob_stall", 32'(bus.out_stall_reason), 32'd1);
    chk("rob_count", 32'(dut.count_q), 32'd4);
    chk("rob_novalid", 32'(bus.out_decode_valid), 32'd0);
    bus.in_rob_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rob_dvalid", 32'(bus.out_decode_valid), 32'd1);
      chk("rob_dinstr", bus.out_decode_instr, 32'h00000013 | (32'(i) << 20));
      chk("rob_dpc", bus.out_decode_pc, 32'h10 + 32'(i) * 4);
    end
    chk("rob_stall0", 32'(bus.out_stall_reason), 32'd0);
    tick();
    chk("rob_end", 32'(bus.out_decode_valid), 32'd0);
    chk("rob_runstate", 32'(dut.state_q), 32'd0);

    // LSB full blocks LW; ADD waits behind it
    bus.in_lsb_full = 1'b1;
    drive(1'b1, 32'h00002103, 32'h100, 1'b0);
    tick();
    drive(1'b1, 32'h002081B3, 32'h104, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("lsb_valid", 32'(bus.out_decode_valid), 32'd0);
    chk("lsb_stall", 32'(bus.out_stall_reason), 32'd3);
    chk("lsb_count", 32'(dut.count_q), 32'd2);
    chk("lsb_state", 32'(dut.state_q), 32'd1);
    bus.in_lsb_full = 1'b0;
    tick();
    chk("lsb_d0", bus.out_decode_instr, 32'h00002103);
    chk("lsb_d0v", 32'(bus.out_decode_valid), 32'd1);
    tick();
    chk("lsb_d1", bus.out_decode_instr, 32'h002081B3);
    chk("lsb_d1pc", bus.out_decode_pc, 32'h104);
    tick();
    chk("lsb_end", 32'(bus.out_decode_valid), 32'd0);

    // RS full blocks an ALU op
    bus.in_rs_full = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h108, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("rs_stall", 32'(bus.out_stall_reason), 32'd2);
    chk("rs_valid", 32'(bus.out_decode_valid), 32'd0);
    bus.in_rs_full = 1'b0;
    tick();
    chk("rs_dvalid", 32'(bus.out_decode_valid), 32'd1);
    chk("rs_dpc", bus.out_decode_pc, 32'h108);
    tick();

    // flush with 3 queued and a same-cycle push
    bus.in_rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00000033, 32'h400 + 32'(i) * 4, 1'b0);
      tick();
    end
    chk("fl_pre_count", 32'(dut.count_q), 32'd3);
    drive(1'b1, 32'h00000033, 32'h40C, 1'b0);
    bus.in_rob_flush = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    bus.in_rob_flush = 1'b0;
    bus.in_rob_full  = 1'b0;
    chk("fl_count", 32'(dut.count_q), 32'd0);
    chk("fl_valid", 32'(bus.out_decode_valid), 32'd0);
    chk("fl_ready", 32'(bus.out_fetcher_ready), 32'd0);
    chk("fl_stall", 32'(bus.out_stall_reason), 32'd0);
    chk("fl_state", 32'(dut.state_q), 32'd2);
    tick();
    chk("fl_ready1", 32'(bus.out_fetcher_ready), 32'd1);
    chk("fl_state1", 32'(dut.state_q), 32'd0);
    chk("fl_valid1", 32'(bus.out_decode_valid), 32'd0);

    // invalid opcode dropped, next RS op follows
    drive(1'b1, 32'h0000000F, 32'h200, 1'b0);
    tick();
    chk("inv_v0", 32'(bus.out_decode_valid), 32'd0);
    drive(1'b1, 32'h00500093, 32'h204, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("inv_v1", 32'(bus.out_decode_valid), 32'd0);
    chk("inv_count", 32'(dut.count_q), 32'd1);
    tick();
    chk("inv_dvalid", 32'(bus.out_decode_valid), 32'd1);
    chk("inv_dinstr", bus.out_decode_instr, 32'h00500093);
    chk("inv_dpc", bus.out_decode_pc, 32'h204);
    chk("inv_djce", 32'(bus.out_decode_jump_ce), 32'd1);
    tick();
    chk("inv_end", 32'(bus.out_decode_valid), 32'd0);

    // 10-instruction stream across wrap with rdy low for 3 cycles
    pushed  = 0;
    got     = 0;
    st_frz  = 32'h0;
    cnt_frz = 32'h0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      rdy = !(cyc >= 4 && cyc < 7);
      drive(pushed < 10, 32'h00000013 | (32'(pushed) << 20), 32'h300 + 32'(pushed) * 4, 1'b0);
      if (cyc == 4) begin
        st_frz  = 32'(dut.state_q);
        cnt_frz = 32'(dut.count_q);
      end
      will_push = bus.in_fetcher_valid && bus.out_fetcher_ready && rdy;
      tick();
      if (will_push) pushed++;
      if (!rdy) begin
        chk("wr_frz_state", 32'(dut.state_q), st_frz);
        chk("wr_frz_count", 32'(dut.count_q), cnt_frz);
      end else if (bus.out_decode_valid) begin
        exp_i = 32'h00000013 | (32'(got) << 20);
        chk("wr_instr", bus.out_decode_instr, exp_i);
        chk("wr_pc", bus.out_decode_pc, 32'h300 + 32'(got) * 4);
        got++;
      end
    end
    rdy = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("wr_total", 32'(got), 32'd10);
    tick();
    chk("wr_nodup", 32'(bus.out_decode_valid), 32'd0);

    // asynchronous reset mid-operation discards the queue
    bus.in_rob_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h00000033, 32'h500, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", 32'(dut.count_q), 32'd0);
    chk("ar_stall", 32'(bus.out_stall_reason), 32'd0);
    chk("ar_pc", bus.out_decode_pc, 32'h0);
    tick();
    rst = 1'b0;
    bus.in_rob_full = 1'b0;
    chk("ar_ready", 32'(bus.out_fetcher_ready), 32'd1);
    tick();
    chk("ar_valid", 32'(bus.out_decode_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
